read_rw: RTL
============

// Module: read_rw
// PURPOSE
//  Read stage of the per-tile RW pipeline, upstream of the write stage.
//  - Accepts dispatched RW tasks and issues a read of the task's object word to the L1 data array (ar/r channel).
//  - Pairs each response with its pending task and extracts the RW word.
//  - Emits an rw_write_t bundle (task_desc, object data, cq_slot, thread) to the write stage.
//  - Undo-log-restore tasks bypass the read and carry their restore data straight through.
// PARAMETERS
//  TILE_ID          0    tile index (debug readback only)
//  MAX_OUTSTANDING  8    max reads in flight; must be <= number of thread ids
// PORTS
//  clk               in   1         clock
//  rstn              in   1         asynchronous active-low reset
//  task_in_valid     in   1         dispatched task present
//  task_in_ready     out  1         task accepted this cycle
//  task_in           in   rw_read_t task_desc, cq_slot, thread, undo_data
//  arvalid           out  1         read request valid
//  arready           in   1         L1 accepts request
//  araddr            out  32        byte address into data array (bypasses tags)
//  arid              out  id_t      = task thread id
//  rvalid            in   1         read response valid
//  rready            out  1         response accepted
//  rdata             in   512       full cache line
//  rid               in   id_t      thread id of response
//  task_out_valid    out  1         bundle to write stage valid
//  task_out_ready    in   1         write stage accepts
//  task_out          out  rw_write_t bundle (object = extracted word)
//  reg_bus           --   reg_bus_t config / debug register interface
// BEHAVIOUR
//  Reset (async, rstn=0): arvalid, task_out_valid, rready-derived state, pending[] bits, outstanding count, err_sticky all 0.
//    base_rw_addr = 0. reg_bus.rvalid = 0.
//  Config: RW_BASE_ADDR write sets base_rw_addr = {wdata[29:0],2'b00}.
//  Address: araddr = base_rw_addr + (task_desc.object << LOG_RW_WIDTH), computed in 32 bits, wraps mod 2^32.
//  AR register: single entry. Load allowed when !arvalid | arready.
//    arvalid holds with stable araddr/arid until arready.
//  Read task accepted (task_in_ready=1, ttype != UNDO_LOG_RESTORE) iff all of:
//    - AR register loadable;
//    - !pending[task_in.thread];
//    - outstanding < MAX_OUTSTANDING.
//    On accept: next cycle arvalid=1; pend_tab[thread] <= {task_desc, cq_slot}; pending[thread] <= 1; outstanding+1.
//  Output register: single entry; free = !task_out_valid | task_out_ready.
//  Response: rready = free. On rvalid & rready, with index = rid:
//    - If pending[rid]: next cycle task_out_valid=1; task_out = {pend_tab[rid].task_desc, word, cq_slot, thread=rid};
//      pending[rid] <= 0; outstanding-1.
//    - Word extraction, off = object low bits: W=2^LOG_RW_WIDTH*8; word = rdata[off*W +: W];
//      off width = 6-LOG_RW_WIDTH (LOG_RW_WIDTH=6: whole line).
//    - rid not pending: response dropped, err_sticky <= 1, no output, counters unchanged.
//  Undo tasks: accepted iff free & !(rvalid & rready) (response has priority). Output next cycle with object = undo_data.
//  Simultaneous accept+response: outstanding net unchanged.
//    Same-thread set and clear in the same cycle is impossible (accept requires !pending).
//  Latency: task accept -> arvalid 1 cycle. r handshake -> task_out_valid 1 cycle. Undo accept -> task_out_valid 1 cycle.
//  Responses may return out of order; output order follows response order.
//  reg_bus read (rvalid 1 cycle after arvalid):
//    - 8'h80 cycles_no_task
//    - 8'h84 tasks_issued
//    - 8'h88 outstanding
//    - 8'h8c {31'b0, err_sticky}
//    - CORE_DEBUG_WORD handshake bits
//  Reset mid-operation: all in-flight state discarded; late responses after reset hit !pending -> err_sticky.
// STRUCTURE
//  chronos package: rw_read_t typedef (task_desc, cq_slot, thread, undo_data); reuse rw_write_t, id_t, LOG_RW_WIDTH.
//  Sub-module rw_word_extract (combinational line -> word mux by offset), shareable with other RW stages.
//  pend_tab: flop array indexed by thread id; pending bitvector beside it.
// TESTING
//  1 base=0x1000, object=5, LOG_RW_WIDTH=2, thread 3 -> araddr=0x1014, arid=3; rdata word[5]=0xDEAD -> task_out.object=0xDEAD, thread 3.
//  2 Issue threads 1,2; responses rid=2 then rid=1 -> two outputs in that order, each with the matching cq_slot; outstanding returns to 0.
//  3 MAX_OUTSTANDING=2, 3 tasks, no responses -> third task_in_ready=0 until one response completes.
//  4 task_out_ready=0 while rvalid held -> rready=0, no loss; release -> single output per response.
//  5 Undo task with undo_data=0x55 concurrent with a response -> response output first, undo output next cycle; no ar issued for undo.
//  6 rvalid with rid=7 not pending -> no output, reg 8'h8c reads 1; assert rstn=0 mid-flight -> all valids 0 immediately.

Source files
------------

// File: rtl/read_rw_pkg.sv
// Shared types for the RW pipeline stages: task bundles, thread ids and register map.
package read_rw_pkg;

    localparam int LOG_RW_WIDTH = 2;
    localparam int RW_W         = 8 << LOG_RW_WIDTH;
    localparam int LINE_W       = 512;
    localparam int OFF_W        = (LOG_RW_WIDTH >= 6) ? 1 : 6 - LOG_RW_WIDTH;
    localparam int THREAD_W     = 4;

    typedef logic [THREAD_W-1:0] id_t;
    typedef logic [5:0]          cq_slot_t;

    typedef enum logic [1:0] {
        TT_RW               = 2'd0,
        TT_UNDO_LOG_RESTORE = 2'd1
    } ttype_t;

    typedef struct packed {
        ttype_t      ttype;
        logic [31:0] object;
        logic [15:0] ts;
    } task_desc_t;

    typedef struct packed {
        task_desc_t      task_desc;
        cq_slot_t        cq_slot;
        id_t             thread;
        logic [RW_W-1:0] undo_data;
    } rw_read_t;

    typedef struct packed {
        task_desc_t      task_desc;
        logic [RW_W-1:0] object;
        cq_slot_t        cq_slot;
        id_t             thread;
    } rw_write_t;

    typedef struct packed {
        task_desc_t task_desc;
        cq_slot_t   cq_slot;
    } pend_entry_t;

    typedef struct packed {
        logic        arvalid;
        logic [7:0]  araddr;
        logic        wvalid;
        logic [7:0]  waddr;
        logic [31:0] wdata;
    } reg_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
    } reg_rsp_t;

    localparam logic [7:0] RW_BASE_ADDR       = 8'h40;
    localparam logic [7:0] REG_CYCLES_NO_TASK = 8'h80;
    localparam logic [7:0] REG_TASKS_ISSUED   = 8'h84;
    localparam logic [7:0] REG_OUTSTANDING    = 8'h88;
    localparam logic [7:0] REG_ERR            = 8'h8c;
    localparam logic [7:0] CORE_DEBUG_WORD    = 8'h90;

endpackage

// File: rtl/read_rw_word_extract.sv
// Selects one RW word out of a cache line by word offset.
// Latency: combinational.
// Backpressure: none, pure datapath.
module rw_word_extract
    import read_rw_pkg::*;
#(
    parameter int LOG_W    = LOG_RW_WIDTH,
    parameter int OFF_BITS = (LOG_W >= 6) ? 1 : 6 - LOG_W
) (
    input  logic [LINE_W-1:0]     line,
    input  logic [OFF_BITS-1:0]   off,
    output logic [(8<<LOG_W)-1:0] word
);

    localparam int W = 8 << LOG_W;

    generate
        if (LOG_W >= 6) begin : g_whole
            assign word = line[W-1:0];
        end else begin : g_mux
            logic [LINE_W/W-1:0][W-1:0] words;
            assign words = line;
            assign word  = words[off];
        end
    endgenerate

endmodule

// File: rtl/read_rw.sv
// Read stage of the RW pipeline: issues object reads, pairs responses with pending tasks.
// Latency: task accept -> arvalid 1 cycle; r handshake or undo accept -> task_out_valid 1 cycle.
// Backpressure: single-entry AR and output registers; rready follows output-register space.
module read_rw
    import read_rw_pkg::*;
#(
    parameter int TILE_ID         = 0,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              task_in_valid,
    output logic              task_in_ready,
    input  rw_read_t          task_in,
    output logic              arvalid,
    input  logic              arready,
    output logic [31:0]       araddr,
    output id_t               arid,
    input  logic              rvalid,
    output logic              rready,
    input  logic [LINE_W-1:0] rdata,
    input  id_t               rid,
    output logic              task_out_valid,
    input  logic              task_out_ready,
    output rw_write_t         task_out,
    input  reg_req_t          reg_bus_req,
    output reg_rsp_t          reg_bus_rsp
);

    localparam int NUM_THREADS = 1 << THREAD_W;
    localparam int CNT_W       = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_THREADS-1:0] pending;
    pend_entry_t            pend_tab [NUM_THREADS];
    logic [CNT_W-1:0]       outstanding;
    logic [31:0]            base_rw_addr;
    logic [31:0]            cycles_no_task;
    logic [31:0]            tasks_issued;
    logic                   err_sticky;

    logic        is_undo, ar_loadable, out_free, resp_fire, resp_hit;
    logic        read_acc, undo_acc;
    pend_entry_t rsp_entry;
    logic [RW_W-1:0] rsp_word;
    logic [31:0] obj_addr, reg_rdata_nxt, debug_word;
    logic [1:0]  wdata_unused;

    assign is_undo     = task_in.task_desc.ttype == TT_UNDO_LOG_RESTORE;
    assign ar_loadable = !arvalid || arready;
    assign out_free    = !task_out_valid || task_out_ready;
    assign rready      = out_free;
    assign resp_fire   = rvalid && rready;
    assign resp_hit    = resp_fire && pending[rid];

    // Responses own the output register, so an undo task waits out any r handshake.
    assign task_in_ready = is_undo ? (out_free && !resp_fire)
                                   : (ar_loadable && !pending[task_in.thread] &&
                                      (outstanding < CNT_W'(MAX_OUTSTANDING)));
    assign read_acc = task_in_valid && task_in_ready && !is_undo;
    assign undo_acc = task_in_valid && task_in_ready && is_undo;

    assign obj_addr     = base_rw_addr + (task_in.task_desc.object << LOG_RW_WIDTH);
    assign rsp_entry    = pend_tab[rid];
    assign wdata_unused = reg_bus_req.wdata[31:30];

    rw_word_extract #(.LOG_W(LOG_RW_WIDTH)) u_extract (
        .line (rdata),
        .off  (rsp_entry.task_desc.object[OFF_W-1:0]),
        .word (rsp_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arid    <= '0;
        end else if (read_acc) begin
            arvalid <= 1'b1;
            araddr  <= obj_addr;
            arid    <= task_in.thread;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (read_acc) begin
            pend_tab[task_in.thread].task_desc <= task_in.task_desc;
            pend_tab[task_in.thread].cq_slot   <= task_in.cq_slot;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending     <= '0;
            outstanding <= '0;
            err_sticky  <= 1'b0;
        end else begin
            if (read_acc) pending[task_in.thread] <= 1'b1;
            if (resp_hit) pending[rid] <= 1'b0;
            if (read_acc && !resp_hit)      outstanding <= outstanding + CNT_W'(1);
            else if (!read_acc && resp_hit) outstanding <= outstanding - CNT_W'(1);
            if (resp_fire && !pending[rid]) err_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            task_out_valid <= 1'b0;
            task_out       <= '0;
        end else if (resp_hit) begin
            task_out_valid     <= 1'b1;
            task_out.task_desc <= rsp_entry.task_desc;
            task_out.object    <= rsp_word;
            task_out.cq_slot   <= rsp_entry.cq_slot;
            task_out.thread    <= rid;
        end else if (undo_acc) begin
            task_out_valid     <= 1'b1;
            task_out.task_desc <= task_in.task_desc;
            task_out.object    <= task_in.undo_data;
            task_out.cq_slot   <= task_in.cq_slot;
            task_out.thread    <= task_in.thread;
        end else if (task_out_ready) begin
            task_out_valid <= 1'b0;
        end
    end

    assign debug_word = {8'(TILE_ID), 16'b0,
                         task_in_valid, task_in_ready, arvalid, arready,
                         rvalid, rready, task_out_valid, task_out_ready};

    always_comb begin
        reg_rdata_nxt = '0;
        case (reg_bus_req.araddr)
            REG_CYCLES_NO_TASK: reg_rdata_nxt = cycles_no_task;
            REG_TASKS_ISSUED:   reg_rdata_nxt = tasks_issued;
            REG_OUTSTANDING:    reg_rdata_nxt = 32'(outstanding);
            REG_ERR:            reg_rdata_nxt = {31'b0, err_sticky};
            CORE_DEBUG_WORD:    reg_rdata_nxt = debug_word;
            default:            reg_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_rw_addr   <= '0;
            cycles_no_task <= '0;
            tasks_issued   <= '0;
            reg_bus_rsp    <= '0;
        end else begin
            if (reg_bus_req.wvalid && reg_bus_req.waddr == RW_BASE_ADDR)
                base_rw_addr <= {reg_bus_req.wdata[29:0], 2'b00};
            if (!task_in_valid) cycles_no_task <= cycles_no_task + 32'd1;
            if (read_acc)       tasks_issued   <= tasks_issued + 32'd1;
            reg_bus_rsp.rvalid <= reg_bus_req.arvalid;
            if (reg_bus_req.arvalid) reg_bus_rsp.rdata <= reg_rdata_nxt;
        end
    end

endmodule
